// File: rtl/tl_mem_slave.sv
// TileLink-UL responder over a byte-lane-writable register array, one transaction in flight.
// Optional alignment/mask checking is enabled by defining TL_MEM_SLAVE_MASK_CHECK_EN.

`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 4
`endif
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 3
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 4
`endif
`ifndef TL_SINK_BITS
`define TL_SINK_BITS 1
`endif
`ifndef TL_A_PUTFULL
`define TL_A_PUTFULL 3'd0
`endif
`ifndef TL_A_PUTPARTIAL
`define TL_A_PUTPARTIAL 3'd1
`endif
`ifndef TL_A_GET
`define TL_A_GET 3'd4
`endif
`ifndef TL_D_ACCESSACK
`define TL_D_ACCESSACK 3'd0
`endif
`ifndef TL_D_ACCESSACKDATA
`define TL_D_ACCESSACKDATA 3'd1
`endif

module tl_mem_slave #(
    parameter int unsigned              DEPTH     = 256,
    parameter logic [`TL_ADDR_BITS-1:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned              LATENCY   = 0,
    parameter int unsigned              SINK_ID   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [2:0]                    a_opcode,
    input  logic [2:0]                    a_param,
    input  logic [`TL_SIZE_BITS-1:0]      a_size,
    input  logic [`TL_SOURCE_BITS-1:0]    a_source,
    input  logic [`TL_ADDR_BITS-1:0]      a_address,
    input  logic [`TL_DATA_BYTES-1:0]     a_mask,
    input  logic [`TL_DATA_BYTES*8-1:0]   a_data,
    output logic                          d_valid,
    input  logic                          d_ready,
    output logic [2:0]                    d_opcode,
    output logic [1:0]                    d_param,
    output logic [`TL_SIZE_BITS-1:0]      d_size,
    output logic [`TL_SOURCE_BITS-1:0]    d_source,
    output logic [`TL_SINK_BITS-1:0]      d_sink,
    output logic                          d_denied,
    output logic [`TL_DATA_BYTES*8-1:0]   d_data
);
    localparam int DB        = `TL_DATA_BYTES;
    localparam int DW        = DB * 8;
    localparam int AW        = `TL_ADDR_BITS;
    localparam int SINK_BITS = `TL_SINK_BITS;
    localparam int ADDR_LSB  = $clog2(DB);
    localparam int IDX_W     = $clog2(DEPTH);

    localparam logic [AW:0]          WIN_LO  = {1'b0, BASE_ADDR};
    localparam logic [AW:0]          WIN_HI  = WIN_LO + (AW + 1)'(DEPTH * DB);
    localparam logic [3:0]           LAT_CNT = 4'(LATENCY);
    localparam logic [SINK_BITS-1:0] SINK    = SINK_BITS'(SINK_ID);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                      state;
    logic [3:0]                  cnt;
    logic [2:0]                  req_opcode;
    logic [`TL_SIZE_BITS-1:0]    req_size;
    logic [`TL_SOURCE_BITS-1:0]  req_source;
    logic [AW-1:0]               req_addr;
    logic [DB-1:0]               req_mask;
    logic [DW-1:0]               req_data;

    logic [DW-1:0]  mem [DEPTH];
    logic [IDX_W-1:0] idx;
    logic           in_range, size_ok, op_ok, mask_ok, denied, is_get, is_put, wr_en;

    logic unused_param;
    assign unused_param = ^a_param;

    assign idx    = req_addr[ADDR_LSB +: IDX_W];
    assign is_get = (req_opcode == `TL_A_GET);
    assign is_put = (req_opcode == `TL_A_PUTFULL) || (req_opcode == `TL_A_PUTPARTIAL);

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin : decode
        int off;
        int blk;
        logic [DB-1:0] exp_mask;
        off      = 0;
        blk      = 1;
        exp_mask = '0;
        in_range = ({1'b0, req_addr} >= WIN_LO) && ({1'b0, req_addr} < WIN_HI);
        size_ok  = (int'(req_size) <= ADDR_LSB);
        op_ok    = is_get || is_put;
        mask_ok  = 1'b1;
`ifdef TL_MEM_SLAVE_MASK_CHECK_EN
        if (size_ok) begin
            off = int'(req_addr & AW'(DB - 1));
            blk = 1 << req_size;
            // A lane is expected when it sits in the same 2^size block as the address.
            for (int b = 0; b < DB; b++) begin
                exp_mask[b] = ((b / blk) == (off / blk));
            end
            if ((off % blk) != 0)
                mask_ok = 1'b0;
            else if (req_opcode == `TL_A_PUTPARTIAL)
                mask_ok = ((req_mask & ~exp_mask) == '0);
            else
                mask_ok = (req_mask == exp_mask);
        end
`endif
        denied = !(in_range && size_ok && op_ok && mask_ok);
    end

    assign wr_en = (state == ACCESS) && (cnt == '0) && is_put && !denied;

    // NOTE: the array is deliberately left out of reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DB; b++) begin
                if (req_mask[b]) mem[idx][b*8 +: 8] <= req_data[b*8 +: 8];
            end
        end
    end

    // NOTE: sequential state uses <= so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            a_ready    <= 1'b0;
            d_valid    <= 1'b0;
            d_opcode   <= '0;
            d_param    <= '0;
            d_size     <= '0;
            d_source   <= '0;
            d_sink     <= '0;
            d_denied   <= 1'b0;
            d_data     <= '0;
            req_opcode <= '0;
            req_size   <= '0;
            req_source <= '0;
            req_addr   <= '0;
            req_mask   <= '0;
            req_data   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    a_ready <= 1'b1;
                    if (a_valid && a_ready) begin
                        req_opcode <= a_opcode;
                        req_size   <= a_size;
                        req_source <= a_source;
                        req_addr   <= a_address;
                        req_mask   <= a_mask;
                        req_data   <= a_data;
                        cnt        <= LAT_CNT;
                        a_ready    <= 1'b0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        d_valid  <= 1'b1;
                        d_opcode <= is_get ? `TL_D_ACCESSACKDATA : `TL_D_ACCESSACK;
                        d_param  <= '0;
                        d_size   <= req_size;
                        d_source <= req_source;
                        d_sink   <= SINK;
                        d_denied <= denied;
                        d_data   <= (is_get && !denied) ? mem[idx] : '0;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (d_ready) begin
                        d_valid <= 1'b0;
                        a_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
